rom_dl_sequencer: RTL
=====================

// Module: rom_dl_sequencer
// PURPOSE
//  Sequences the HPS ROM download stream (ioctl_*) into the game core's ROM regions and owns the core reset.
//  It decodes each download byte to a one-hot region write strobe and registers address/data by one stage.
//  It holds the core in reset from power-up until a valid download completes, plus a settle tail.
//  It flags length and range errors.
//  Sits between hps_io and the core (ultra_tank dn_* ports), clocked on clk_sys.
// PARAMETERS
//  NUM_REGIONS  4       number of ROM regions (1..8)
//  SEL_LSB      11      lowest ioctl_addr bit used as region index (2 KB regions)
//  SEL_W        3       width of region index field
//  EXP_LEN      8192    expected total download length in bytes
//  HOLD_CYCLES  4096    core-reset tail after download ends / soft reset (>=1)
//  EXP_SUM      8'h00   expected 8-bit additive checksum (ROM_CHECKSUM_EN only)
// PORTS
//  clk_sys         in   1   system clock (12 MHz)
//  reset           in   1   async, active-high; clears all state
//  ioctl_download  in   1   download window from hps_io
//  ioctl_wr        in   1   byte strobe, one cycle
//  ioctl_addr      in   25  byte address
//  ioctl_dout      in   8   byte data
//  soft_reset      in   1   OSD/button reset request (level)
//  rom_wr          out  NUM_REGIONS  one-hot region write strobe
//  rom_addr        out  SEL_LSB      offset within region
//  rom_data        out  8   write data
//  core_reset      out  1   active-high reset to core
//  dl_done         out  1   a download has completed without error since reset
//  dl_error        out  1   last download had a length, range or checksum error (sticky until next download)
//  byte_count      out  16  bytes accepted in current/last download
// BEHAVIOUR
//  Reset values: rom_wr=0, rom_addr=0, rom_data=0, core_reset=1, dl_done=0, dl_error=0, byte_count=0, state=BOOT.
//  States:
//   - BOOT: core_reset=1.
//   - LOAD: core_reset=1.
//   - HOLD: core_reset=1; hold counter runs.
//   - RUN: core_reset=0.
//  Transitions:
//   - BOOT->LOAD: ioctl_download=1; clears byte_count, dl_error and dl_done.
//   - RUN->LOAD: same condition and clears.
//   - LOAD->HOLD: ioctl_download=0 and no error. Error -> BOOT with dl_error=1.
//   - HOLD->RUN: after exactly HOLD_CYCLES cycles in HOLD; sets dl_done=1 on entry to RUN.
//   - HOLD->LOAD: ioctl_download=1; counter cleared.
//   - RUN->HOLD: soft_reset=1. soft_reset=1 while in HOLD reloads the counter.
//   - soft_reset is ignored in BOOT and LOAD.
//  Write path (LOAD only, including the cycle download rises):
//   - When ioctl_wr=1, region idx = ioctl_addr[SEL_LSB+:SEL_W].
//   - Next cycle rom_wr[idx]=1 for exactly one cycle; rom_addr=ioctl_addr[SEL_LSB-1:0]; rom_data=ioctl_dout.
//   - Latency is 1 cycle; no backpressure; back-to-back strobes are supported every cycle.
//   - idx>=NUM_REGIONS or any ioctl_addr bit above the index field set: no strobe, range error latched, byte still counted.
//   - ioctl_wr outside LOAD: ignored, no count.
//  byte_count increments per accepted strobe and saturates at 16'hFFFF.
//  On download fall, length error iff byte_count (including a strobe in the falling cycle) != EXP_LEN.
//  rom_addr and rom_data hold their last value between strobes.
//  An async reset mid-download aborts: state BOOT, all outputs return to their reset values, and a partial ROM image is not trusted.
// CONFIGURATION
//  ROM_CHECKSUM_EN defined:
//   - 8-bit wrapping sum of all accepted bytes, cleared on LOAD entry.
//   - At download end, sum != EXP_SUM is an error: ->BOOT with dl_error=1.
//  ROM_CHECKSUM_EN undefined:
//   - No sum logic; EXP_SUM unused; only length and range errors exist.
// TESTING
//  T1 Full load:
//   - 8192 strobes at addr 0..8191, 1/cycle, download falls.
//   - Expect rom_wr one-hot idx=addr>>11, 1 cycle late.
//   - core_reset=1 for 4096 cycles after fall, then 0; dl_done=1, byte_count=8192.
//  T2 Short load:
//   - 8000 bytes, download falls.
//   - Expect state BOOT, dl_error=1, core_reset stays 1, dl_done=0.
//  T3 Range:
//   - One write at addr 0x2000 (idx 4) in a 8192-byte load.
//   - Expect no rom_wr pulse for that byte, dl_error=1 at end.
//  T4 Soft reset:
//   - In RUN pulse soft_reset 1 cycle.
//   - Expect core_reset=1 next cycle for 4096 cycles; re-pulse at cycle 2000 extends to 6096.
//  T5 Interrupts:
//   - Assert reset mid-LOAD: all outputs to reset values at once.
//   - Re-raise download during HOLD: back to LOAD, byte_count=0.
//  T6 Checksum (ROM_CHECKSUM_EN, EXP_SUM=8'h5A):
//   - Image summing to 8'h5A gives RUN; 8'h5B gives dl_error=1.

Source files
------------

// File: rtl/rom_dl_sequencer_if.sv
// HPS ROM download stream (ioctl_*) as seen between hps_io and rom_dl_sequencer.
interface rom_dl_sequencer_if;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;

   modport master (output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout);
   modport slave  (input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout);
endinterface

// File: rtl/rom_dl_sequencer.sv
// Routes the ioctl ROM download into one-hot region writes and owns the core reset.
// Optional checksum check of the whole image is enabled with `define ROM_CHECKSUM_EN.
module rom_dl_sequencer #(
   parameter int         NUM_REGIONS = 4,
   parameter int         SEL_LSB     = 11,
   parameter int         SEL_W       = 3,
   parameter int         EXP_LEN     = 8192,
   parameter int         HOLD_CYCLES = 4096,
   parameter logic [7:0] EXP_SUM     = 8'h00
) (
   input  logic                   clk_sys,
   input  logic                   reset,
   rom_dl_sequencer_if.slave      dl,
   input  logic                   soft_reset,
   output logic [NUM_REGIONS-1:0] rom_wr,
   output logic [SEL_LSB-1:0]     rom_addr,
   output logic [7:0]             rom_data,
   output logic                   core_reset,
   output logic                   dl_done,
   output logic                   dl_error,
   output logic [15:0]            byte_count
);
   localparam int                HCW         = $clog2(HOLD_CYCLES + 1);
   localparam logic [HCW-1:0]    HOLD_RELOAD = HCW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {BOOT, LOAD, HOLD, RUN} state_t;

   state_t         state;
   logic [HCW-1:0] hold_cnt;
   logic           range_err;

   logic             load_entry, in_load, acc, hit, range_bad, fall, err_now;
   logic             hi_clear, idx_ok, len_bad, sum_bad;
   logic [SEL_W-1:0] sel_idx;
   logic [15:0]      count_nx;

   function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic inc);
      sat_inc = (inc && c != 16'hFFFF) ? c + 16'd1 : c;
   endfunction

   function automatic logic [NUM_REGIONS-1:0] region_strobe(input logic [SEL_W-1:0] idx);
      region_strobe = NUM_REGIONS'(1) << idx;
   endfunction

`ifdef ROM_CHECKSUM_EN
   logic [7:0] sum_q, sum_nx;
   always_comb begin
      sum_nx  = (load_entry ? 8'h00 : sum_q) + (acc ? dl.ioctl_dout : 8'h00);
      sum_bad = (sum_nx != EXP_SUM);
   end
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)        sum_q <= 8'h00;
      else if (in_load) sum_q <= sum_nx;
   end
`else
   logic [7:0] exp_sum_unused;
   assign exp_sum_unused = EXP_SUM;
   assign sum_bad        = 1'b0;
`endif

   // Strobe qualification: the cycle download rises already belongs to the load,
   // and a strobe in the falling cycle is still counted.
   always_comb begin
      load_entry = (state != LOAD) && dl.ioctl_download;
      in_load    = (state == LOAD) || load_entry;
      acc        = in_load && dl.ioctl_wr;
      sel_idx    = dl.ioctl_addr[SEL_LSB +: SEL_W];
      hi_clear   = (dl.ioctl_addr >> (SEL_LSB + SEL_W)) == 25'd0;
      idx_ok     = {{(32-SEL_W){1'b0}}, sel_idx} < 32'(NUM_REGIONS);
      hit        = acc && hi_clear && idx_ok;
      range_bad  = acc && !hit;
      count_nx   = load_entry ? {15'd0, acc} : sat_inc(byte_count, acc);
      fall       = (state == LOAD) && !dl.ioctl_download;
      len_bad    = (count_nx != 16'(EXP_LEN));
      err_now    = len_bad || range_err || range_bad || sum_bad;
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state      <= BOOT;
         hold_cnt   <= '0;
         range_err  <= 1'b0;
         rom_wr     <= '0;
         rom_addr   <= '0;
         rom_data   <= 8'h00;
         core_reset <= 1'b1;
         dl_done    <= 1'b0;
         dl_error   <= 1'b0;
         byte_count <= 16'd0;
      end else begin
         // Write path: one registered stage, address/data hold between strobes
         rom_wr <= hit ? region_strobe(sel_idx) : '0;
         if (hit) begin
            rom_addr <= dl.ioctl_addr[SEL_LSB-1:0];
            rom_data <= dl.ioctl_dout;
         end
         if (in_load) begin
            byte_count <= count_nx;
            range_err  <= (load_entry ? 1'b0 : range_err) | range_bad;
         end

         if (fall) begin
            if (err_now) begin
               state    <= BOOT;
               dl_error <= 1'b1;
            end else begin
               state    <= HOLD;
               hold_cnt <= HOLD_RELOAD;
            end
         end else if (load_entry) begin
            state      <= LOAD;
            hold_cnt   <= '0;
            dl_error   <= 1'b0;
            dl_done    <= 1'b0;
            core_reset <= 1'b1;
         end else if (state == HOLD) begin
            if (soft_reset) begin
               hold_cnt <= HOLD_RELOAD;
            end else if (hold_cnt == '0) begin
               state      <= RUN;
               core_reset <= 1'b0;
               dl_done    <= 1'b1;
            end else begin
               hold_cnt <= hold_cnt - 1'b1;
            end
         end else if (state == RUN && soft_reset) begin
            state      <= HOLD;
            hold_cnt   <= HOLD_RELOAD;
            core_reset <= 1'b1;
         end
      end
   end
endmodule
